// File: rtl/key_repeat.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_repeat
// Brief    : Pushbutton synchronizer/debouncer with press, release and
//            auto-repeat step pulses.
// Revision : 1.0
// ============================================================================
module key_repeat #(
    parameter int DB_CYCLES  = 16,
    parameter int REP_DELAY  = 1000,
    parameter int REP_PERIOD = 200
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic PB,
    input  logic REP_EN,
    output logic PB_state,
    output logic PB_down,
    output logic PB_up,
    output logic PB_rpt,
    output logic HELD
);

    localparam int c_DB_W    = $clog2(DB_CYCLES);
    localparam int c_TMR_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int c_TMR_W   = $clog2(c_TMR_MAX);

    localparam logic [c_DB_W-1:0]  c_DB_LAST     = c_DB_W'(DB_CYCLES - 1);
    localparam logic [c_TMR_W-1:0] c_DELAY_LAST  = c_TMR_W'(REP_DELAY - 1);
    localparam logic [c_TMR_W-1:0] c_PERIOD_LAST = c_TMR_W'(REP_PERIOD - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } state_t;

    logic [1:0]         r_sync;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic               r_level;
    logic               r_down;
    logic               r_up;
    state_t             r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic               r_rpt;

    logic               w_cand;
    logic               w_differ;
    logic               w_accept;
    logic               w_press;
    logic               w_release;
    state_t             w_state_nxt;
    logic [c_TMR_W-1:0] w_tmr_nxt;
    logic               w_rpt_nxt;

    // PB is active-low, so the inverted synchronizer output is the "pressed" candidate
    assign w_cand    = ~r_sync[1];
    assign w_differ  = (w_cand != r_level);
    assign w_accept  = w_differ && (r_db_cnt == c_DB_LAST);
    assign w_press   = w_accept && w_cand;
    assign w_release = w_accept && !w_cand;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync   <= 2'b11;
            r_db_cnt <= '0;
            r_level  <= 1'b0;
            r_down   <= 1'b0;
            r_up     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], PB};
            r_down <= w_press;
            r_up   <= w_release;
            if (w_accept) begin
                r_level  <= w_cand;
                r_db_cnt <= '0;
            end else if (w_differ) begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_tmr   <= '0;
            r_rpt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tmr   <= w_tmr_nxt;
            r_rpt   <= w_rpt_nxt;
        end
    end

    // Release is tested first in every state so it beats a coincident timer expiry
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_nxt   = r_tmr;
        w_rpt_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_press) begin
                    w_state_nxt = S_DELAY;
                    w_tmr_nxt   = '0;
                    w_rpt_nxt   = 1'b1;
                end
            end
            S_DELAY: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                end else if (REP_EN) begin
                    if (r_tmr == c_DELAY_LAST) begin
                        w_state_nxt = S_REPEAT;
                        w_tmr_nxt   = '0;
                        w_rpt_nxt   = 1'b1;
                    end else begin
                        w_tmr_nxt = r_tmr + c_TMR_W'(1);
                    end
                end
            end
            S_REPEAT: begin
                if (w_release) begin
                    w_state_nxt = S_IDLE;
                    w_tmr_nxt   = '0;
                end else if (!REP_EN) begin
                    w_state_nxt = S_DELAY;
                    w_tmr_nxt   = '0;
                end else if (r_tmr == c_PERIOD_LAST) begin
                    w_tmr_nxt = '0;
                    w_rpt_nxt = 1'b1;
                end else begin
                    w_tmr_nxt = r_tmr + c_TMR_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tmr_nxt   = '0;
            end
        endcase
    end

    assign PB_state = r_level;
    assign PB_down  = r_down;
    assign PB_up    = r_up;
    assign PB_rpt   = r_rpt;
    assign HELD     = (r_state == S_REPEAT);

endmodule
`default_nettype wire

// File: tb/tb_key_repeat.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_key_repeat
// Brief    : Scoreboard bench for key_repeat against a behavioural model.
// Revision : 1.0
// ============================================================================
module tb_key_repeat;

    localparam int DB = 16;
    localparam int RD = 1000;
    localparam int RP = 200;

    logic CLK    = 1'b0;
    logic RST_N  = 1'b0;
    logic PB     = 1'b1;
    logic REP_EN = 1'b0;
    logic PB_state, PB_down, PB_up, PB_rpt, HELD;

    key_repeat #(
        .DB_CYCLES (DB),
        .REP_DELAY (RD),
        .REP_PERIOD(RP)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .PB      (PB),
        .REP_EN  (REP_EN),
        .PB_state(PB_state),
        .PB_down (PB_down),
        .PB_up   (PB_up),
        .PB_rpt  (PB_rpt),
        .HELD    (HELD)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic [4:0] exp_q[$];
    logic [4:0] last_e = '0;

    // Behavioural reference: raw-sample delay line, window of recent candidate
    // levels, and a count of enabled hold cycles since the last (re)arm.
    logic          m_s1 = 1'b1, m_s2 = 1'b1;
    logic [DB-1:0] m_win = '0;
    logic          m_level = 1'b0, m_active = 1'b0, m_rep = 1'b0;
    int            m_ticks = 0;

    task automatic model_edge(input logic pb, input logic en, input logic rst,
                              output logic [4:0] e);
        logic cand, acc, press, rel, rpt;
        if (!rst) begin
            m_s1 = 1'b1; m_s2 = 1'b1; m_win = '0;
            m_level = 1'b0; m_active = 1'b0; m_rep = 1'b0; m_ticks = 0;
            e = '0;
        end else begin
            cand  = ~m_s2;
            m_s2  = m_s1;
            m_s1  = pb;
            m_win = {m_win[DB-2:0], cand};
            acc   = (m_win == {DB{~m_level}});
            press = acc && cand;
            rel   = acc && !cand;
            rpt   = 1'b0;
            if (acc) m_level = cand;
            if (rel) begin
                m_active = 1'b0; m_rep = 1'b0; m_ticks = 0;
            end else if (press) begin
                m_active = 1'b1; m_rep = 1'b0; m_ticks = 0; rpt = 1'b1;
            end else if (m_active) begin
                if (en) begin
                    m_ticks++;
                    if (!m_rep && m_ticks == RD) begin
                        m_rep = 1'b1; m_ticks = 0; rpt = 1'b1;
                    end else if (m_rep && m_ticks == RP) begin
                        m_ticks = 0; rpt = 1'b1;
                    end
                end else if (m_rep) begin
                    m_rep = 1'b0; m_ticks = 0;
                end
            end
            e = {m_level, press, rel, rpt, m_rep};
        end
    endtask

    task automatic check(input string nm, input logic [4:0] got, input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%b exp=%b (state,down,up,rpt,held)", nm, cyc, got, exp);
        end
    endtask

    // One step = one rising edge; inputs change on the falling edge.
    task automatic step(input logic pb, input logic en, input logic rst);
        logic [4:0] e;
        @(negedge CLK);
        PB = pb; REP_EN = en; RST_N = rst;
        model_edge(pb, en, rst, e);
        last_e = e;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        logic [4:0] e;
        forever begin
            @(posedge CLK);
            #2;
            cyc++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("outputs", {PB_state, PB_down, PB_up, PB_rpt, HELD}, e);
            end
        end
    end

    initial begin : reset_monitor
        forever begin
            @(negedge RST_N);
            #1;
            check("async_reset", {PB_state, PB_down, PB_up, PB_rpt, HELD}, 5'b0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int len;
        logic pb, en;
        repeat (4) step(1'b1, 1'b0, 1'b0);
        repeat (10) step(1'b1, 1'b1, 1'b1);

        // Short glitches never reach the debounce threshold
        repeat (5) begin
            repeat (15) step(1'b0, 1'b1, 1'b1);
            repeat (25) step(1'b1, 1'b1, 1'b1);
        end

        // Steady press with repeat enabled, then release
        repeat (1540) step(1'b0, 1'b1, 1'b1);
        repeat (40) step(1'b1, 1'b1, 1'b1);

        // Release acceptance landing exactly on the second repeat expiry
        for (int i = 0; i < 1100 && !(last_e[1] && last_e[0]); i++) step(1'b0, 1'b1, 1'b1);
        repeat (182) step(1'b0, 1'b1, 1'b1);
        repeat (40) step(1'b1, 1'b1, 1'b1);

        // Repeat disabled during a long hold, then enabled
        repeat (3000) step(1'b0, 1'b0, 1'b1);
        repeat (1100) step(1'b0, 1'b1, 1'b1);
        repeat (40) step(1'b1, 1'b1, 1'b1);

        // Reset while repeating with the button still held
        repeat (1100) step(1'b0, 1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (40) step(1'b0, 1'b1, 1'b1);
        repeat (40) step(1'b1, 1'b1, 1'b1);

        // Randomized bursts: bounce, long holds, enable toggling, occasional reset
        for (int b = 0; b < 40; b++) begin
            pb  = 1'($urandom_range(0, 1));
            en  = ($urandom_range(0, 3) != 0);
            len = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1000, 1500))
                                              : int'($urandom_range(1, 40));
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 299) == 0) en = ~en;
                step(pb, en, 1'b1);
            end
            if ($urandom_range(0, 19) == 0) repeat (2) step(pb, en, 1'b0);
        end
        repeat (40) step(1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
        if (exp_q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain got=%0d exp=0 pending entries", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
